alu_seq_multdiv: RTL

- Parametrised-width, handshaked successor to the 32-bit combinational ALU.
- Keeps the ADD/SUB/AND/OR/SLL/SRA opcode set and the isNotEqual/isLessThan/overflow flags.
- Adds iterative signed MUL and DIV, a registered output with valid/ready backpressure, and divide-by-zero reporting.
- Sits between decode and writeback in the processor datapath.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core_comb.sv | 52 +++++
 rtl/alu_seq_multdiv.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and overflow helper for alu_seq_multdiv
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DIV_FIX
  } state_t;

  // Signed add overflow from operand and result sign bits (pass ~b_sign for subtraction)
  function automatic logic signed_ovf(input logic a_sign, input logic b_sign, input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/alu_core_comb.sv
// rtl/alu_core_comb.sv - combinational ADD/SUB/AND/OR/SLL/SRA with ne/lt/overflow flags
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic [4:0]       opcode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ne,
  output logic             lt,
  output logic             ovf
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             sub_ovf;
  logic             legal;

  assign sum     = a + b;
  assign diff    = a - b;
  assign sub_ovf = signed_ovf(a[WIDTH-1], ~b[WIDTH-1], diff[WIDTH-1]);
  assign legal   = (opcode[4:3] == 2'b00);

  // XOR with the subtract overflow keeps the signed compare right when A-B wraps
  assign ne = legal && (diff != '0);
  assign lt = legal && (diff[WIDTH-1] ^ sub_ovf);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum;
        ovf    = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = sub_ovf;
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLL:  result = a << shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_multdiv.sv
// rtl/alu_seq_multdiv.sv - handshaked ALU with iterative Booth multiply and restoring divide
module alu_seq_multdiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ctrl_ALUopcode,
  input  logic [SHW-1:0]   ctrl_shiftamt,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             isNotEqual,
  output logic             isLessThan,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic             accept;
  logic             can_load;
  logic             last_step;

  logic [WIDTH-1:0] core_result;
  logic             core_ne;
  logic             core_lt;
  logic             core_ovf;

  logic             ne_hold;
  logic             lt_hold;

  // Booth state: {acc, mq, mq_m1} shifts right as one register; acc has a guard bit for MIN
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] mq;
  logic             mq_m1;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mq_next;
  logic             mul_ovf;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             quo_neg;
  logic             div_ovf_hold;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  alu_core_comb #(.WIDTH(WIDTH)) u_core (
    .opcode (ctrl_ALUopcode),
    .shamt  (ctrl_shiftamt),
    .a      (data_operandA),
    .b      (data_operandB),
    .result (core_result),
    .ne     (core_ne),
    .lt     (core_lt),
    .ovf    (core_ovf)
  );

  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign can_load  = !out_valid || out_ready;
  assign last_step = (cnt == SHW'(WIDTH - 1));

  always_comb begin
    case ({mq[0], mq_m1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
  end

  assign acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign mq_next  = {booth_sum[0], mq[WIDTH-1:1]};
  // Product fits in WIDTH signed bits only if everything above bit WIDTH-2 is pure sign
  assign mul_ovf  = !((&{acc_next, mq_next[WIDTH-1]}) || !(|{acc_next, mq_next[WIDTH-1]}));

  // Partial remainder stays below the divisor, so the trial difference sign is exact in WIDTH+1 bits
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, dvsr};
  assign div_ge    = !div_trial[WIDTH];

  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      out_valid    <= 1'b0;
      data_result  <= '0;
      isNotEqual   <= 1'b0;
      isLessThan   <= 1'b0;
      overflow     <= 1'b0;
      div_by_zero  <= 1'b0;
      ne_hold      <= 1'b0;
      lt_hold      <= 1'b0;
      acc          <= '0;
      mcand        <= '0;
      mq           <= '0;
      mq_m1        <= 1'b0;
      rem          <= '0;
      quo          <= '0;
      dvsr         <= '0;
      quo_neg      <= 1'b0;
      div_ovf_hold <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            ne_hold <= core_ne;
            lt_hold <= core_lt;
            cnt     <= '0;
            if (ctrl_ALUopcode == OP_MUL) begin
              state <= S_MUL;
              acc   <= '0;
              mcand <= {data_operandA[WIDTH-1], data_operandA};
              mq    <= data_operandB;
              mq_m1 <= 1'b0;
            end else if (ctrl_ALUopcode == OP_DIV && data_operandB != '0) begin
              state        <= S_DIV;
              rem          <= '0;
              quo          <= a_mag;
              dvsr         <= b_mag;
              quo_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
              div_ovf_hold <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
            end else begin
              out_valid   <= 1'b1;
              data_result <= core_result;
              isNotEqual  <= core_ne;
              isLessThan  <= core_lt;
              overflow    <= core_ovf;
              div_by_zero <= (ctrl_ALUopcode == OP_DIV);
            end
          end
        end

        S_MUL: begin
          if (!last_step || can_load) begin
            acc   <= acc_next;
            mq    <= mq_next;
            mq_m1 <= mq[0];
            cnt   <= cnt + 1'b1;
          end
          if (last_step && can_load) begin
            state       <= S_IDLE;
            out_valid   <= 1'b1;
            data_result <= mq_next;
            isNotEqual  <= ne_hold;
            isLessThan  <= lt_hold;
            overflow    <= mul_ovf;
            div_by_zero <= 1'b0;
          end
        end

        S_DIV: begin
          rem <= div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], div_ge};
          cnt <= cnt + 1'b1;
          if (last_step) state <= S_DIV_FIX;
        end

        S_DIV_FIX: begin
          if (can_load) begin
            state       <= S_IDLE;
            out_valid   <= 1'b1;
            data_result <= quo_neg ? -quo : quo;
            isNotEqual  <= ne_hold;
            isLessThan  <= lt_hold;
            overflow    <= div_ovf_hold;
            div_by_zero <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
